// File: rtl/sysbus_pkg.sv
// Shared types and constants for the system-bus fabric.
package sysbus_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Region fields are held at the widest supported address width and zero-extended.
    localparam int unsigned MAX_AW = 32;
    localparam int unsigned WAIT_W = 4;

    typedef struct packed {
        logic [MAX_AW-1:0] base;
        logic [MAX_AW-1:0] mask;
        logic [WAIT_W-1:0] wait_cyc;
    } region_t;

    localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hff;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational master picker: fixed lowest-index priority or round-robin after ptr.
module rr_arbiter #(
    parameter int unsigned NM = 2,
    parameter int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] slot;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        slot  = '0;
        for (int k = 0; k < int'(NM); k++) begin
            slot = mode ? IW'((32'(ptr) + 32'(k) + 32'd1) % NM) : IW'(k);
            if (!found && req[slot]) begin
                found     = 1'b1;
                gnt[slot] = 1'b1;
                idx       = slot;
            end
        end
    end

endmodule

// File: rtl/sysbus_fabric.sv
// CPU-side bus interconnect: arbitrates NM masters onto one bus, decodes NR regions
// and generates per-region selects with programmable wait states.
module sysbus_fabric
    import sysbus_pkg::*;
#(
    parameter int unsigned       NM          = 2,
    parameter int unsigned       NR          = 4,
    parameter int unsigned       AW          = 16,
    parameter int unsigned       DW          = 8,
    parameter int unsigned       ARB_MODE    = ARB_FIXED,
    parameter logic [NR*AW-1:0]  REGION_BASE = {16'h0000, 16'h6000, 16'h8000, 16'h4000},
    parameter logic [NR*AW-1:0]  REGION_MASK = {16'he000, 16'he000, 16'h8000, 16'hffe0},
    parameter logic [NR*WAIT_W-1:0] REGION_WAIT = {4'd0, 4'd0, 4'd1, 4'd2},
    parameter logic [DW-1:0]     OPEN_BUS    = DW'(OPEN_BUS_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM-1:0]    m_req,
    input  logic [NM-1:0]    m_lock,
    input  logic [NM*AW-1:0] m_addr,
    input  logic [NM-1:0]    m_we,
    input  logic [NM*DW-1:0] m_wdata,
    output logic [NM-1:0]    m_gnt,
    output logic [NM-1:0]    m_rdy,
    output logic [DW-1:0]    m_rdata,
    output logic [NR-1:0]    s_sel,
    output logic [AW-1:0]    s_addr,
    output logic             s_we,
    output logic [DW-1:0]    s_wdata,
    input  logic [NR*DW-1:0] s_rdata,
    output logic             bus_err
);

    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned RW = (NR > 1) ? $clog2(NR) : 1;

    state_t            state, state_next;
    logic [IW-1:0]     owner, ptr, arb_idx;
    logic [NM-1:0]     arb_gnt;
    logic              entry, miss_q;
    logic [RW-1:0]     hit_q;
    logic [WAIT_W-1:0] cnt;

    logic [AW-1:0]     own_addr;
    logic [DW-1:0]     own_wdata, hit_rdata;
    logic              own_req, own_lock, own_we;
    logic [RW-1:0]     dec_hit, cur_hit;
    logic              dec_miss, cur_miss, active, done;
    logic [WAIT_W-1:0] cur_cnt;

    region_t region [NR];

    // Region table: the first listed entry of each parameter is region 0.
    for (genvar g = 0; g < NR; g++) begin : g_region
        assign region[g] = '{base:     MAX_AW'(REGION_BASE[(NR-1-g)*AW +: AW]),
                             mask:     MAX_AW'(REGION_MASK[(NR-1-g)*AW +: AW]),
                             wait_cyc: REGION_WAIT[(NR-1-g)*WAIT_W +: WAIT_W]};
    end

    rr_arbiter #(.NM(NM), .IW(IW)) u_arb (
        .req  (m_req),
        .ptr  (ptr),
        .mode (ARB_MODE == ARB_RR),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // Owner's request fields.
    always_comb begin
        own_addr  = '0;
        own_wdata = '0;
        own_req   = 1'b0;
        own_lock  = 1'b0;
        own_we    = 1'b0;
        for (int i = 0; i < int'(NM); i++) begin
            if (owner == IW'(i)) begin
                own_addr  = m_addr[i*AW +: AW];
                own_wdata = m_wdata[i*DW +: DW];
                own_req   = m_req[i];
                own_lock  = m_lock[i];
                own_we    = m_we[i];
            end
        end
    end

    // Priority decode: lowest-index region wins on overlap.
    always_comb begin
        dec_hit  = '0;
        dec_miss = 1'b1;
        for (int i = int'(NR) - 1; i >= 0; i--) begin
            if ((MAX_AW'(own_addr) & region[i].mask) == region[i].base) begin
                dec_hit  = RW'(i);
                dec_miss = 1'b0;
            end
        end
    end

    // Decode is only taken on the entry cycle; later cycles reuse the latched result.
    always_comb begin
        cur_hit   = entry ? dec_hit  : hit_q;
        cur_miss  = entry ? dec_miss : miss_q;
        cur_cnt   = cnt;
        if (entry) begin
            cur_cnt = dec_miss ? '0 : region[dec_hit].wait_cyc;
        end
        active    = (state == ACCESS) && own_req;
        done      = active && (cur_cnt == '0);
        hit_rdata = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (cur_hit == RW'(i)) begin
                hit_rdata = s_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|arb_gnt) state_next = ACCESS;
            ACCESS:  if (!own_req || (done && !own_lock)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner  <= '0;
            ptr    <= IW'(NM - 1);
            entry  <= 1'b0;
            hit_q  <= '0;
            miss_q <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (|arb_gnt) begin
                owner <= arb_idx;
                entry <= 1'b1;
            end
        end else begin
            // A locked completion re-enters with a fresh decode.
            entry <= done;
            if (entry) begin
                hit_q  <= dec_hit;
                miss_q <= dec_miss;
            end
            cnt <= (cur_cnt == '0) ? '0 : cur_cnt - WAIT_W'(1);
            if (state_next == IDLE) begin
                ptr <= owner;
            end
        end
    end

    always_comb begin
        m_gnt   = '0;
        m_rdy   = '0;
        m_rdata = '0;
        s_sel   = '0;
        s_addr  = '0;
        s_we    = 1'b0;
        s_wdata = '0;
        bus_err = 1'b0;
        if (state == ACCESS) begin
            m_gnt[owner] = 1'b1;
        end
        if (active) begin
            s_addr  = own_addr;
            s_wdata = own_wdata;
            s_we    = own_we && !cur_miss;
            if (!cur_miss) begin
                s_sel[cur_hit] = 1'b1;
            end
            if (done) begin
                m_rdy[owner] = 1'b1;
                bus_err      = cur_miss;
                if (!own_we) begin
                    m_rdata = cur_miss ? OPEN_BUS : hit_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sysbus_fabric.sv
// Bench for sysbus_fabric: one fixed-priority and one round-robin instance on shared stimulus.
module tb_sysbus_fabric;

    logic        clk;
    logic        reset;
    logic [1:0]  m_req, m_lock, m_we;
    logic [31:0] m_addr;
    logic [15:0] m_wdata;
    logic [31:0] s_rdata;

    logic [1:0]  f_gnt, f_rdy, r_gnt, r_rdy;
    logic [7:0]  f_rdata, r_rdata, f_swdata, r_swdata;
    logic [3:0]  f_sel, r_sel;
    logic [15:0] f_saddr, r_saddr;
    logic        f_swe, r_swe, f_err, r_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [3:0]  sel;
        logic        swe;
        int          lat;
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    vec_t vecs [11];
    vec_t sb [$];

    sysbus_fabric #(.ARB_MODE(0)) u_fix (
        .clk(clk), .reset(reset), .m_req(m_req), .m_lock(m_lock), .m_addr(m_addr),
        .m_we(m_we), .m_wdata(m_wdata), .m_gnt(f_gnt), .m_rdy(f_rdy), .m_rdata(f_rdata),
        .s_sel(f_sel), .s_addr(f_saddr), .s_we(f_swe), .s_wdata(f_swdata),
        .s_rdata(s_rdata), .bus_err(f_err)
    );

    sysbus_fabric #(.ARB_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .m_req(m_req), .m_lock(m_lock), .m_addr(m_addr),
        .m_we(m_we), .m_wdata(m_wdata), .m_gnt(r_gnt), .m_rdy(r_rdy), .m_rdata(r_rdata),
        .s_sel(r_sel), .s_addr(r_saddr), .s_we(r_swe), .s_wdata(r_swdata),
        .s_rdata(s_rdata), .bus_err(r_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        m_req   = '0;
        m_lock  = '0;
        m_we    = '0;
        m_addr  = '0;
        m_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Single master-0 transfer: expectations queued at drive time, checked at m_rdy.
    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        bit   seen;
        m_req         = 2'b01;
        m_addr[15:0]  = v.addr;
        m_we          = {1'b0, v.we};
        m_wdata[7:0]  = v.wdata;
        sb.push_back(v);
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d gnt c%0d", idx, c), 32'(f_gnt), (c == 0) ? 32'd0 : 32'd1);
            if (c > 0) begin
                chk($sformatf("v%0d sel c%0d", idx, c), 32'(f_sel), 32'(v.sel));
                chk($sformatf("v%0d s_we c%0d", idx, c), 32'(f_swe), 32'(v.swe));
            end
            if (f_rdy[0]) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d unexpected rdy", idx), 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d latency", idx), 32'(c), 32'(e.lat));
                    chk($sformatf("v%0d rdata", idx), 32'(f_rdata), 32'(e.rdata));
                    chk($sformatf("v%0d bus_err", idx), 32'(f_err), 32'(e.err));
                end
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            chk($sformatf("v%0d rdy timeout", idx), 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        m_req = '0;
        m_we  = '0;
        @(negedge clk);
        chk($sformatf("v%0d gnt idle", idx), 32'(f_gnt), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_exp [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] fx_exp [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [1:0] lk_exp [6] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

    initial begin
        s_rdata = 32'hc396_7e5a;
        //          addr      we    wdata  sel      swe   lat rdata  err
        vecs[0]  = '{16'h0123, 1'b0, 8'h00, 4'b0001, 1'b0, 1, 8'h5a, 1'b0};
        vecs[1]  = '{16'h4004, 1'b0, 8'h00, 4'b1000, 1'b0, 3, 8'hc3, 1'b0};
        vecs[2]  = '{16'h5000, 1'b0, 8'h00, 4'b0000, 1'b0, 1, 8'hff, 1'b1};
        vecs[3]  = '{16'h5000, 1'b1, 8'h11, 4'b0000, 1'b0, 1, 8'h00, 1'b1};
        vecs[4]  = '{16'h8000, 1'b0, 8'h00, 4'b0100, 1'b0, 2, 8'h96, 1'b0};
        vecs[5]  = '{16'h6001, 1'b1, 8'h3c, 4'b0010, 1'b1, 1, 8'h00, 1'b0};
        vecs[6]  = '{16'h1fff, 1'b0, 8'h00, 4'b0001, 1'b0, 1, 8'h5a, 1'b0};
        vecs[7]  = '{16'h401f, 1'b0, 8'h00, 4'b1000, 1'b0, 3, 8'hc3, 1'b0};
        vecs[8]  = '{16'h4020, 1'b0, 8'h00, 4'b0000, 1'b0, 1, 8'hff, 1'b1};
        vecs[9]  = '{16'hffff, 1'b0, 8'h00, 4'b0100, 1'b0, 2, 8'h96, 1'b0};
        vecs[10] = '{16'h7fff, 1'b0, 8'h00, 4'b0010, 1'b0, 1, 8'h7e, 1'b0};

        do_reset();
        @(negedge clk);
        chk("rst gnt", 32'(f_gnt), 32'd0);
        chk("rst rdy", 32'(f_rdy), 32'd0);
        chk("rst sel", 32'(f_sel), 32'd0);
        chk("rst s_we", 32'(f_swe), 32'd0);
        chk("rst err", 32'(f_err), 32'd0);
        chk("rst rdata", 32'(f_rdata), 32'd0);
        chk("rst s_addr", 32'(f_saddr), 32'd0);
        chk("rst s_wdata", 32'(f_swdata), 32'd0);
        chk("rst rr gnt", 32'({r_gnt, r_rdy, r_sel, r_swe, r_err}), 32'd0);
        chk("rst rr bus", 32'({r_rdata, r_saddr, r_swdata}), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        // Both masters requesting continuously, no lock.
        do_reset();
        m_req  = 2'b11;
        m_addr = {16'h0123, 16'h0123};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("rr gnt c%0d", c), 32'(r_gnt), 32'(rr_exp[c]));
            chk($sformatf("rr rdy c%0d", c), 32'(r_rdy), 32'(rr_exp[c]));
            chk($sformatf("fix gnt c%0d", c), 32'(f_gnt), 32'(fx_exp[c]));
            @(posedge clk);
            #1;
        end
        m_req = '0;
        @(posedge clk);
        #1;

        // Locked burst by master 1 with master 0 waiting.
        do_reset();
        m_lock         = 2'b10;
        m_we           = 2'b10;
        m_addr         = {16'h6000, 16'h0123};
        m_wdata        = 16'ha000;
        m_req          = 2'b10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("lock fix gnt c%0d", c), 32'(f_gnt), 32'(lk_exp[c]));
            chk($sformatf("lock fix rdy c%0d", c), 32'(f_rdy), 32'(lk_exp[c]));
            chk($sformatf("lock rr gnt c%0d", c), 32'(r_gnt), 32'(lk_exp[c]));
            if (lk_exp[c] == 2'b10) begin
                chk($sformatf("lock s_addr c%0d", c), 32'(f_saddr), 32'(16'h6000 + 16'(c - 1)));
                chk($sformatf("lock s_we c%0d", c), 32'({f_swe, f_sel}), 32'(5'b1_0010));
                chk($sformatf("lock s_wdata c%0d", c), 32'(f_swdata), 32'(8'ha0));
            end
            @(posedge clk);
            #1;
            case (c)
                0: m_req[0] = 1'b1;
                1: m_addr[31:16] = 16'h6001;
                2: begin m_addr[31:16] = 16'h6002; m_lock = '0; end
                3: m_req[1] = 1'b0;
                default: ;
            endcase
        end
        m_req = '0;
        m_we  = '0;
        @(posedge clk);
        #1;

        // Owner drops its request mid-wait.
        do_reset();
        m_req        = 2'b01;
        m_addr[15:0] = 16'h4004;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort sel c1", 32'(f_sel), 32'(4'b1000));
        @(posedge clk);
        #1 m_req = '0;
        @(negedge clk);
        chk("abort sel c2", 32'(f_sel), 32'd0);
        chk("abort rdy c2", 32'(f_rdy), 32'd0);
        chk("abort gnt c2", 32'(f_gnt), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort gnt c3", 32'(f_gnt), 32'd0);
        chk("abort rdy c3", 32'(f_rdy), 32'd0);
        @(posedge clk);
        #1;

        // Reset during a wait state; round-robin pointer must return to master 0 first.
        do_reset();
        run_vec(vecs[0], 100);
        m_req        = 2'b01;
        m_addr[15:0] = 16'h4004;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("mid pre gnt", 32'(f_gnt), 32'd1);
        chk("mid pre rdy", 32'({f_rdy, r_rdy}), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid rst gnt", 32'({f_gnt, r_gnt}), 32'd0);
        chk("mid rst rdy", 32'({f_rdy, r_rdy}), 32'd0);
        chk("mid rst sel", 32'({f_sel, r_sel}), 32'd0);
        m_addr = {16'h0123, 16'h0123};
        m_req  = 2'b11;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post rst gnt c0", 32'(r_gnt), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post rst rr gnt", 32'(r_gnt), 32'd1);
        chk("post rst rr rdy", 32'(r_rdy), 32'd1);
        chk("post rst fix gnt", 32'(f_gnt), 32'd1);
        @(posedge clk);
        #1 m_req = '0;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
